// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Purpose : shared definitions for the multi-cycle radix-2 restoring divider.
//           Holds the default operand width and the 2-bit FSM encodings so
//           the divider, its interface and any pipeline glue agree on them.
// Contents: DIV_WIDTH             default operand width
//           DIV_IDLE/BUSY/DONE    2-bit state encodings
//           divState_e            FSM state type built on those encodings
// ---------------------------------------------------------------------------
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = DIV_IDLE,
        ST_BUSY = DIV_BUSY,
        ST_DONE = DIV_DONE
    } divState_e;

endpackage

// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if
// Purpose : bundle of the EX-stage request and response signals of the
//           divider.
// Signals : start       EX holds a DIV/DIVU (held high for the whole stall)
//           signed_div  1 = DIV, 0 = DIVU
//           annul       cancel any operation in flight
//           a, b        dividend and divisor
//           alu_ready   0 = divide in progress, stall the pipeline
//           busy        divider is iterating
//           result      {hi = remainder, lo = quotient}
// Modports: master = pipeline side (drives the request)
//           slave  = divider side (drives the response)
// ---------------------------------------------------------------------------
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic               start;
    logic               signed_div;
    logic               annul;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               alu_ready;
    logic               busy;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, signed_div, annul, a, b,
        input  alu_ready, busy, result
    );

    modport slave (
        input  start, signed_div, annul, a, b,
        output alu_ready, busy, result
    );

endinterface

// File: rtl/div_unit_step.sv
// ---------------------------------------------------------------------------
// div_unit_step
// Purpose : one combinational restoring-division iteration. Shifts the
//           {remainder, quotient} pair left by one, trial-subtracts the
//           divisor and keeps the difference when it is non-negative.
// Ports   : rem_i      partial remainder (always < divisor_i)
//           quo_i      remaining dividend bits / quotient being built
//           divisor_i  divisor magnitude
//           rem_o      next partial remainder
//           quo_o      next quotient word, new bit shifted in at the LSB
// ---------------------------------------------------------------------------
module div_unit_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The shifted remainder needs one extra bit, so the trial subtract is
    // done WIDTH+1 bits wide and its top bit is the borrow (negative result).
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Purpose : multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//           Works on magnitudes, then fixes the signs of quotient and
//           remainder. alu_ready low stalls the pipeline until the one-cycle
//           DONE state, where result = {hi = remainder, lo = quotient}.
// Ports   : clk   rising-edge clock
//           rst   synchronous active-high reset
//           bus   div_unit_if slave modport (start, signed_div, annul, a, b
//                 in; alu_ready, busy, result out)
// ---------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);

    localparam int              CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    divState_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic               negQuo_q, negQuo_d;
    logic               negRem_q, negRem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   stepRem, stepQuo;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] finalResult;
    logic               aluReady;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (stepRem),
        .quo_o     (stepQuo)
    );

    // Operand conditioning: the iteration only ever sees magnitudes, so
    // negative signed operands are negated before they are latched.
    // The most negative value negates to itself, which is still the correct
    // unsigned magnitude.
    always_comb begin
        magA = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        magB = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // Result shaping for the final iteration: a zero divisor overrides the
    // arithmetic with {dividend, all ones}; otherwise the quotient takes the
    // XOR of the operand signs and the remainder takes the dividend sign.
    always_comb begin
        if (divisor_q == '0) begin
            finalResult = {dividend_q, {WIDTH{1'b1}}};
        end else begin
            finalResult = {(negRem_q ? -stepRem : stepRem),
                           (negQuo_q ? -stepQuo : stepQuo)};
        end
    end

    // Next-state and output logic. DONE always returns to IDLE so a start
    // still held for the finishing instruction cannot restart it; only a start
    // seen in IDLE launches a divide. annul overrides everything at the end.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        negQuo_d   = negQuo_q;
        negRem_d   = negRem_q;
        result_d   = result_q;
        aluReady   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                aluReady = ~bus.start;
                if (bus.start) begin
                    state_d    = ST_BUSY;
                    count_d    = '0;
                    rem_d      = '0;
                    quo_d      = magA;
                    divisor_d  = magB;
                    dividend_d = bus.a;
                    negQuo_d   = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    negRem_d   = bus.signed_div & bus.a[WIDTH-1];
                end
            end
            ST_BUSY: begin
                rem_d   = stepRem;
                quo_d   = stepQuo;
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d  = ST_DONE;
                    result_d = finalResult;
                end
            end
            ST_DONE: begin
                aluReady = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.annul) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            aluReady = 1'b1;
        end
    end

    // State register. Every register is cleared on reset so no X reaches the
    // outputs; an operation in flight is simply discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            negQuo_q   <= 1'b0;
            negRem_q   <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            negQuo_q   <= negQuo_d;
            negRem_q   <= negRem_d;
            result_q   <= result_d;
        end
    end

    assign bus.alu_ready = aluReady;
    assign bus.busy      = (state_q == ST_BUSY);
    assign bus.result    = result_q;

endmodule
